mips_mc_control: RTL and testbench

//  Multicycle MIPS control FSM. It sequences the shared datapath: PC, IR, the A/B

---
 rtl/mips_mc_pkg.sv | 45 ++++
 rtl/mips_mc_ctrl_decode.sv | 95 +++++++++
 rtl/mips_mc_control.sv | 116 +++++++++++
 tb/tb_mips_mc_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The opcode set listed here is the only one the sequencer accepts.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXECUTE   = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_ADDI_EX   = 4'd10,
      ST_ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Control decode: Moore outputs per state, with the IR load and the PC increment
// in FETCH qualified by mem_ready. All outputs are held at 0 while en is low.
module mips_mc_ctrl_decode
   import mips_mc_pkg::*;
(
   input  logic       en,
   input  state_t     state,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       ab_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write
);

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      ab_write      = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALU_ADD;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;

      if (en) begin
         case (state)
            ST_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               alu_src_b = SRCB_IMM_SH;
               ab_write  = 1'b1;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
               reg_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control: state register, next-state logic, illegal-opcode
// flag and retired-instruction counter around the control decode.
//
//  state        | meaning
//  -------------+------------------------------------------------
//  ST_FETCH     | read instruction at PC, PC+4 on mem_ready
//  ST_DECODE    | latch A/B, precompute branch target, dispatch
//  ST_MEM_ADDR  | ALUOut = A + sign-ext imm (lw/sw)
//  ST_MEM_READ  | read data memory at ALUOut, wait mem_ready
//  ST_MEM_WB    | write MDR to rt
//  ST_MEM_WRITE | write B to memory at ALUOut, wait mem_ready
//  ST_EXECUTE   | R-type ALU operation
//  ST_R_WB      | write ALUOut to rd
//  ST_BRANCH    | compare A/B, load PC with target if zero
//  ST_JUMP      | load PC with jump target
//  ST_ADDI_EX   | ALUOut = A + sign-ext imm
//  ST_ADDI_WB   | write ALUOut to rt
module mips_mc_control
   import mips_mc_pkg::*;
#(
   parameter int unsigned RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5:0]              opcode,
   input  logic                    mem_ready,
   output logic                    pc_write,
   output logic                    pc_write_cond,
   output logic [1:0]              pc_source,
   output logic                    i_or_d,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    ir_write,
   output logic                    ab_write,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [1:0]              alu_op,
   output logic                    reg_dst,
   output logic                    mem_to_reg,
   output logic                    reg_write,
   output logic                    illegal_op,
   output logic [RETIRE_CNT_W-1:0] retired
);

   state_t state;
   state_t state_nxt;
   logic   retire_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH:     if (mem_ready) state_nxt = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_nxt = ST_EXECUTE;
               OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
               OP_BEQ:       state_nxt = ST_BRANCH;
               OP_J:         state_nxt = ST_JUMP;
               OP_ADDI:      state_nxt = ST_ADDI_EX;
               default:      state_nxt = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ:  if (mem_ready) state_nxt = ST_MEM_WB;
         ST_MEM_WRITE: if (mem_ready) state_nxt = ST_FETCH;
         ST_EXECUTE:   state_nxt = ST_R_WB;
         ST_ADDI_EX:   state_nxt = ST_ADDI_WB;
         ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                       state_nxt = ST_FETCH;
         default:      state_nxt = ST_FETCH;
      endcase
   end

   // Illegal-opcode returns to FETCH are deliberately not counted here.
   always_comb begin
      retire_evt = 1'b0;
      case (state)
         ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: retire_evt = 1'b1;
         ST_MEM_WRITE: retire_evt = mem_ready;
         default:      retire_evt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          retired <= '0;
      else if (retire_evt) retired <= retired + RETIRE_CNT_W'(1);
   end

   assign illegal_op = rst_n && (state == ST_DECODE) && !op_legal(opcode);

   mips_mc_ctrl_decode u_decode (
      .en            (rst_n),
      .state         (state),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .ab_write      (ab_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write)
   );

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: a 32-bit and a 4-bit retired-counter
// instance run the same instruction stream and are checked every cycle.
module tb_mips_mc_control;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                  S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXECUTE = 6, S_R_WB = 7,
                  S_BRANCH = 8, S_JUMP = 9, S_ADDI_EX = 10, S_ADDI_WB = 11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;

   logic        pcw_a, pcwc_a, iord_a, mr_a, mw_a, irw_a, abw_a, sa_a, rd_a, m2r_a, rw_a, ill_a;
   logic [1:0]  pcs_a, sb_a, aop_a;
   logic [31:0] ret_a;
   logic        pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, abw_b, sa_b, rd_b, m2r_b, rw_b, ill_b;
   logic [1:0]  pcs_b, sb_b, aop_b;
   logic [3:0]  ret_b;

   logic [17:0] ctl_a, ctl_b;
   assign ctl_a = {pcw_a, pcwc_a, pcs_a, iord_a, mr_a, mw_a, irw_a, abw_a, sa_a, sb_a, aop_a,
                   rd_a, m2r_a, rw_a, ill_a};
   assign ctl_b = {pcw_b, pcwc_b, pcs_b, iord_b, mr_b, mw_b, irw_b, abw_b, sa_b, sb_b, aop_b,
                   rd_b, m2r_b, rw_b, ill_b};

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_ret = 0;

   always #5 clk = ~clk;

   mips_mc_control #(.RETIRE_CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pcw_a), .pc_write_cond(pcwc_a), .pc_source(pcs_a), .i_or_d(iord_a),
      .mem_read(mr_a), .mem_write(mw_a), .ir_write(irw_a), .ab_write(abw_a),
      .alu_src_a(sa_a), .alu_src_b(sb_a), .alu_op(aop_a), .reg_dst(rd_a),
      .mem_to_reg(m2r_a), .reg_write(rw_a), .illegal_op(ill_a), .retired(ret_a)
   );

   mips_mc_control #(.RETIRE_CNT_W(4)) dut_w4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pcw_b), .pc_write_cond(pcwc_b), .pc_source(pcs_b), .i_or_d(iord_b),
      .mem_read(mr_b), .mem_write(mw_b), .ir_write(irw_b), .ab_write(abw_b),
      .alu_src_a(sa_b), .alu_src_b(sb_b), .alu_op(aop_b), .reg_dst(rd_b),
      .mem_to_reg(m2r_b), .reg_write(rw_b), .illegal_op(ill_b), .retired(ret_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Expected control word straight from the per-state control table.
   function automatic logic [17:0] exp_ctl(input int st, input bit rdy, input bit ill);
      logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, abw = 0, sa = 0;
      logic rd = 0, m2r = 0, rw = 0;
      logic [1:0] pcs = 2'b00, sb = 2'b00, aop = 2'b00;
      case (st)
         S_FETCH:     begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:    begin sb = 2'b11; abw = 1; end
         S_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
         S_MEM_READ:  begin mr = 1; iord = 1; end
         S_MEM_WB:    begin rw = 1; m2r = 1; end
         S_MEM_WRITE: begin mw = 1; iord = 1; end
         S_EXECUTE:   begin sa = 1; aop = 2'b10; end
         S_R_WB:      begin rw = 1; rd = 1; end
         S_BRANCH:    begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         S_JUMP:      begin pcw = 1; pcs = 2'b10; end
         S_ADDI_EX:   begin sa = 1; sb = 2'b10; end
         S_ADDI_WB:   begin rw = 1; end
         default: ;
      endcase
      return {pcw, pcwc, pcs, iord, mr, mw, irw, abw, sa, sb, aop, rd, m2r, rw,
              (st == S_DECODE) ? ill : 1'b0};
   endfunction

   // Entered at posedge+1; checks one cycle of outputs and moves to the next posedge+1.
   task automatic cyc(input int st, input bit rdy, input bit ill);
      mem_ready = rdy;
      #1;
      chk($sformatf("ctl_st%0d", st),    {14'b0, ctl_a}, {14'b0, exp_ctl(st, rdy, ill)});
      chk($sformatf("ctl_w4_st%0d", st), {14'b0, ctl_b}, {14'b0, exp_ctl(st, rdy, ill)});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input string tag);
      chk(tag,                 ret_a,           exp_ret);
      chk({tag, "_w4"}, {28'b0, ret_b}, {28'b0, exp_ret[3:0]});
   endtask

   task automatic do_instr(input logic [5:0] op, input int fstall, input int mstall);
      bit legal;
      opcode = op;
      legal = (op == 6'h00) || (op == 6'h02) || (op == 6'h04) || (op == 6'h08) ||
              (op == 6'h23) || (op == 6'h2B);
      for (int i = 0; i < fstall; i++) cyc(S_FETCH, 0, 0);
      cyc(S_FETCH, 1, 0);
      cyc(S_DECODE, 1'($urandom_range(0, 1)), !legal);
      case (op)
         6'h00: begin cyc(S_EXECUTE, 1'($urandom_range(0, 1)), 0); cyc(S_R_WB, 1'($urandom_range(0, 1)), 0); exp_ret++; end
         6'h23: begin
            cyc(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < mstall; i++) cyc(S_MEM_READ, 0, 0);
            cyc(S_MEM_READ, 1, 0);
            cyc(S_MEM_WB, 1'($urandom_range(0, 1)), 0);
            exp_ret++;
         end
         6'h2B: begin
            cyc(S_MEM_ADDR, 1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < mstall; i++) cyc(S_MEM_WRITE, 0, 0);
            cyc(S_MEM_WRITE, 1, 0);
            exp_ret++;
         end
         6'h04: begin cyc(S_BRANCH, 1'($urandom_range(0, 1)), 0); exp_ret++; end
         6'h02: begin cyc(S_JUMP, 1'($urandom_range(0, 1)), 0); exp_ret++; end
         6'h08: begin cyc(S_ADDI_EX, 1'($urandom_range(0, 1)), 0); cyc(S_ADDI_WB, 1'($urandom_range(0, 1)), 0); exp_ret++; end
         default: ;
      endcase
      chk_ret($sformatf("retired_op%02h", op));
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'h00;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl",    {14'b0, ctl_a}, 32'd0);
      chk("reset_ctl_w4", {14'b0, ctl_b}, 32'd0);
      chk_ret("reset_retired");
      rst_n = 1'b1;

      do_instr(6'h23, 0, 0);   // lw, no stalls: 5 cycles, retired 0->1
      do_instr(6'h2B, 1, 3);   // sw: mem_write held 4 cycles
      do_instr(6'h00, 0, 0);   // R-type
      do_instr(6'h04, 0, 0);   // beq
      do_instr(6'h02, 0, 0);   // j
      do_instr(6'h3F, 0, 0);   // illegal: pulse in DECODE, not retired
      do_instr(6'h08, 2, 0);   // addi after fetch stalls
      do_instr(6'h23, 0, 2);   // lw with read stalls

      // Reset asserted in the middle of a stalled store.
      opcode = 6'h2B;
      cyc(S_FETCH, 1, 0);
      cyc(S_DECODE, 0, 0);
      cyc(S_MEM_ADDR, 0, 0);
      cyc(S_MEM_WRITE, 0, 0);
      mem_ready = 1'b0;
      #1;
      chk("stall_mem_write", {31'b0, mw_a}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl",    {14'b0, ctl_a}, 32'd0);
      chk("rst_mid_ctl_w4", {14'b0, ctl_b}, 32'd0);
      exp_ret = 0;
      chk_ret("rst_mid_retired");
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      rst_n = 1'b1;
      chk_ret("post_rst_retired");

      // Sixteen addi: the 4-bit counter wraps 15 -> 0.
      for (int i = 0; i < 16; i++) do_instr(6'h08, 0, 0);
      cyc(S_FETCH, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
